// File: rtl/reg_file_sb_if.sv
// Decode/writeback-side signal bundle for the scoreboarded register file.
// The master drives requests, and the slave is the register file.
interface reg_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wbEn;
    logic [ADDR_W-1:0] wbAddr;
    logic [DATA_W-1:0] wbData;
    logic [ADDR_W-1:0] rsAddr;
    logic [DATA_W-1:0] rsData;
    logic [ADDR_W-1:0] rtAddr;
    logic [DATA_W-1:0] rtData;
    logic              rsBusy;
    logic              rtBusy;
    logic              issueEn;
    logic [ADDR_W-1:0] issueAddr;
    logic              flush;
    logic [ADDR_W-1:0] dbgAddr;
    logic [DATA_W-1:0] dbgData;
    logic              sbOverflow;

    modport master (
        output wbEn, wbAddr, wbData, rsAddr, rtAddr, issueEn, issueAddr, flush, dbgAddr,
        input  rsData, rtData, rsBusy, rtBusy, dbgData, sbOverflow
    );

    modport slave (
        input  wbEn, wbAddr, wbData, rsAddr, rtAddr, issueEn, issueAddr, flush, dbgAddr,
        output rsData, rtData, rsBusy, rtBusy, dbgData, sbOverflow
    );
endinterface

// File: rtl/reg_file_sb.sv
// 32x32 register file with writeback bypass on the two decode read ports,
// and per-register pending-write counters for hazard detection.
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int PEND_W = 2
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_sb_if.slave  bus
);
    localparam int NREG = 2 ** ADDR_W;
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [DATA_W-1:0] regs [NREG];
    logic [PEND_W-1:0] pend [NREG];
    logic              overflow_q;
    logic              issue_sat;

    // A retiring write to the same register cancels the increment, so it cannot saturate.
    always_comb begin
        issue_sat = bus.issueEn && (bus.issueAddr != '0)
                    && !(bus.wbEn && (bus.wbAddr == bus.issueAddr))
                    && (pend[bus.issueAddr] == PEND_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                pend[r] <= '0;
            end
            overflow_q <= 1'b0;
        end else begin
            if (bus.wbEn && (bus.wbAddr != '0))
                regs[bus.wbAddr] <= bus.wbData;

            for (int r = 1; r < NREG; r++) begin
                logic inc;
                logic dec;
                inc = bus.issueEn && (bus.issueAddr == ADDR_W'(r));
                dec = bus.wbEn && (bus.wbAddr == ADDR_W'(r));
                if (bus.flush)
                    pend[r] <= inc ? PEND_ONE : '0;
                else if (inc && !dec) begin
                    if (pend[r] != PEND_MAX)
                        pend[r] <= pend[r] + PEND_ONE;
                end else if (dec && !inc) begin
                    if (pend[r] != '0)
                        pend[r] <= pend[r] - PEND_ONE;
                end
            end

            if (bus.flush)
                overflow_q <= 1'b0;
            else if (issue_sat)
                overflow_q <= 1'b1;
        end
    end

    always_comb begin
        bus.rsData = regs[bus.rsAddr];
        if (bus.rsAddr == '0)
            bus.rsData = '0;
        else if (bus.wbEn && (bus.wbAddr == bus.rsAddr))
            bus.rsData = bus.wbData;

        bus.rtData = regs[bus.rtAddr];
        if (bus.rtAddr == '0)
            bus.rtData = '0;
        else if (bus.wbEn && (bus.wbAddr == bus.rtAddr))
            bus.rtData = bus.wbData;

        bus.dbgData = (bus.dbgAddr == '0) ? '0 : regs[bus.dbgAddr];
    end

    // The last outstanding write retiring this cycle is already visible through the bypass.
    always_comb begin
        bus.rsBusy = (pend[bus.rsAddr] != '0)
                     && !(bus.wbEn && (bus.wbAddr == bus.rsAddr) && (pend[bus.rsAddr] == PEND_ONE));
        bus.rtBusy = (pend[bus.rtAddr] != '0)
                     && !(bus.wbEn && (bus.wbAddr == bus.rtAddr) && (pend[bus.rtAddr] == PEND_ONE));
        bus.sbOverflow = overflow_q;
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: bypass, r0 handling, scoreboard saturation,
// flush and asynchronous reset.
module tb_reg_file_sb;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .PEND_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wbEn = 1'b0; bus.wbAddr = '0; bus.wbData = '0;
        bus.issueEn = 1'b0; bus.issueAddr = '0; bus.flush = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        bus.rsAddr = '0; bus.rtAddr = '0; bus.dbgAddr = '0;
        #1 rst = 1'b1;
        #2;
        chk("rst_sbOverflow", 32'(bus.sbOverflow), 32'd0);
        @(negedge clk) rst = 1'b0;

        // After reset, all addresses should read zero and show no pending writes.
        for (int i = 0; i < 32; i++) begin
            bus.rsAddr = 5'(i); bus.rtAddr = 5'(31 - i); bus.dbgAddr = 5'(i);
            #1;
            chk("reset_rd_data", bus.rsData | bus.rtData | bus.dbgData, 32'd0);
            chk("reset_busy", {30'd0, bus.rsBusy, bus.rtBusy}, 32'd0);
        end
        chk("reset_overflow", 32'(bus.sbOverflow), 32'd0);

        // A write to r5 is bypassed to the read ports but not to the debug port.
        step();
        bus.wbEn = 1'b1; bus.wbAddr = 5'd5; bus.wbData = 32'hDEADBEEF;
        bus.rsAddr = 5'd5; bus.rtAddr = 5'd5; bus.dbgAddr = 5'd5;
        #1;
        chk("bypass_rs", bus.rsData, 32'hDEADBEEF);
        chk("bypass_rt", bus.rtData, 32'hDEADBEEF);
        chk("bypass_dbg_old", bus.dbgData, 32'd0);
        step();
        idle();
        #1;
        chk("wr5_dbg", bus.dbgData, 32'hDEADBEEF);
        chk("wr5_rs", bus.rsData, 32'hDEADBEEF);

        // A write to r0 and an issue to r0 must have no effect.
        bus.wbEn = 1'b1; bus.wbAddr = 5'd0; bus.wbData = 32'hFFFFFFFF;
        bus.issueEn = 1'b1; bus.issueAddr = 5'd0; bus.rsAddr = 5'd0; bus.dbgAddr = 5'd0;
        #1;
        chk("r0_bypass", bus.rsData, 32'd0);
        step();
        idle();
        #1;
        chk("r0_rd", bus.rsData, 32'd0);
        chk("r0_dbg", bus.dbgData, 32'd0);
        chk("r0_busy", 32'(bus.rsBusy), 32'd0);
        chk("r0_noovf", 32'(bus.sbOverflow), 32'd0);

        // Issue to r8 three times to saturate its counter, then a fourth issue overflows.
        bus.issueEn = 1'b1; bus.issueAddr = 5'd8; bus.rsAddr = 5'd8;
        step(); step(); step();
        chk("r8_busy_sat", 32'(bus.rsBusy), 32'd1);
        chk("r8_noovf_yet", 32'(bus.sbOverflow), 32'd0);
        step();
        idle();
        #1;
        chk("r8_overflow", 32'(bus.sbOverflow), 32'd1);
        chk("r8_busy_after_ovf", 32'(bus.rsBusy), 32'd1);
        bus.wbEn = 1'b1; bus.wbAddr = 5'd8; bus.wbData = 32'h11;
        #1;
        chk("r8_busy_p3", 32'(bus.rsBusy), 32'd1);
        step();
        bus.wbData = 32'h22;
        #1;
        chk("r8_busy_p2", 32'(bus.rsBusy), 32'd1);
        chk("r8_data_p2", bus.rsData, 32'h22);
        step();
        bus.wbData = 32'h33;
        #1;
        chk("r8_busy_last_bypass", 32'(bus.rsBusy), 32'd0);
        chk("r8_data_last", bus.rsData, 32'h33);
        step();
        idle();
        #1;
        chk("r8_busy_done", 32'(bus.rsBusy), 32'd0);
        chk("r8_data_final", bus.rsData, 32'h33);
        chk("r8_ovf_sticky", 32'(bus.sbOverflow), 32'd1);

        // Writing r11 with nothing pending leaves its counter at zero.
        bus.wbEn = 1'b1; bus.wbAddr = 5'd11; bus.wbData = 32'hB0B; bus.rsAddr = 5'd11;
        step();
        idle();
        #1;
        chk("r11_hold_zero", 32'(bus.rsBusy), 32'd0);
        bus.issueEn = 1'b1; bus.issueAddr = 5'd11;
        step();
        idle();
        bus.wbEn = 1'b1; bus.wbAddr = 5'd11; bus.wbData = 32'hB1B;
        step();
        idle();
        #1;
        chk("r11_one_retire", 32'(bus.rsBusy), 32'd0);

        // A same-cycle issue and writeback on r9 leaves its count unchanged.
        bus.issueEn = 1'b1; bus.issueAddr = 5'd9; bus.rtAddr = 5'd9;
        step();
        bus.wbEn = 1'b1; bus.wbAddr = 5'd9; bus.wbData = 32'h99;
        step();
        idle();
        #1;
        chk("r9_busy_kept", 32'(bus.rtBusy), 32'd1);
        chk("r9_data", bus.rtData, 32'h99);

        // A flush with a concurrent issue to r10 and a writeback to r12.
        bus.flush = 1'b1; bus.issueEn = 1'b1; bus.issueAddr = 5'd10; bus.rsAddr = 5'd10;
        bus.wbEn = 1'b1; bus.wbAddr = 5'd12; bus.wbData = 32'h00C0FFEE; bus.dbgAddr = 5'd12;
        #1;
        chk("pre_flush_r10", 32'(bus.rsBusy), 32'd0);
        step();
        idle();
        #1;
        chk("flush_r9_clear", 32'(bus.rtBusy), 32'd0);
        chk("flush_r10_issue", 32'(bus.rsBusy), 32'd1);
        chk("flush_ovf_clear", 32'(bus.sbOverflow), 32'd0);
        chk("flush_wb_r12", bus.dbgData, 32'h00C0FFEE);
        bus.wbEn = 1'b1; bus.wbAddr = 5'd10; bus.wbData = 32'hA0;
        #1;
        chk("r10_retire_bypass", 32'(bus.rsBusy), 32'd0);
        step();
        idle();
        #1;
        chk("r10_idle", 32'(bus.rsBusy), 32'd0);

        // Load state into r3 and r4, then assert reset asynchronously mid-cycle.
        bus.wbEn = 1'b1; bus.wbAddr = 5'd3; bus.wbData = 32'h33333333;
        step();
        idle();
        bus.issueEn = 1'b1; bus.issueAddr = 5'd4;
        step(); step(); step(); step();
        idle();
        bus.rsAddr = 5'd4; bus.rtAddr = 5'd3; bus.dbgAddr = 5'd3;
        #1;
        chk("pre_rst_r3", bus.dbgData, 32'h33333333);
        chk("pre_rst_busy4", 32'(bus.rsBusy), 32'd1);
        chk("pre_rst_ovf", 32'(bus.sbOverflow), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_r3_rt", bus.rtData, 32'd0);
        chk("async_rst_r3_dbg", bus.dbgData, 32'd0);
        chk("async_rst_busy4", 32'(bus.rsBusy), 32'd0);
        chk("async_rst_ovf", 32'(bus.sbOverflow), 32'd0);
        @(negedge clk) rst = 1'b0;

        // After reset is released, a single issue gives a count of one.
        bus.issueEn = 1'b1; bus.issueAddr = 5'd4;
        step();
        idle();
        bus.wbEn = 1'b1; bus.wbAddr = 5'd4; bus.wbData = 32'h4;
        #1;
        chk("fresh_r4_bypass_clear", 32'(bus.rsBusy), 32'd0);
        step();
        idle();
        #1;
        chk("fresh_r4_data", bus.rsData, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- 32x32 MIPS general-purpose register file with a pending-write scoreboard.
- Sink end of the writeback interface: consumes wbEn/wbAddr/wbData from the writeback stage.
- Serves two decode-stage read ports (rs, rt) with same-cycle write bypass, plus a debug read port.
- Per-register pending-write counters: decode marks a destination on issue, writeback retires it; decode uses the busy flags for hazard stalls.

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 5, register address width; 2**ADDR_W registers.
- PEND_W, 2, width of each pending-write counter; max in-flight writes per register = 2**PEND_W-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wbEn  input  1  writeback write enable.
- wbAddr  input  ADDR_W  writeback destination register.
- wbData  input  DATA_W  writeback data.
- rsAddr  input  ADDR_W  read port A address.
- rsData  output  DATA_W  read port A data.
- rtAddr  input  ADDR_W  read port B address.
- rtData  output  DATA_W  read port B data.
- rsBusy  output  1  register rsAddr has outstanding writes.
- rtBusy  output  1  register rtAddr has outstanding writes.
- issueEn  input  1  decode issuing an instruction that will write a register.
- issueAddr  input  ADDR_W  destination of the issuing instruction.
- flush  input  1  pipeline flush; clears all pending counters.
- dbgAddr  input  ADDR_W  debug read address.
- dbgData  output  DATA_W  debug read data, no bypass.
- sbOverflow  output  1  sticky flag: issue attempted on a saturated counter.

Behaviour:
- Reset (async assert, immediate):
  - All registers cleared to 0.
  - All pending counters cleared to 0.
  - sbOverflow = 0.
  - Read outputs follow the combinational rules below, so they read 0 during reset.
- Register 0:
  - Reads always return 0.
  - Writes to address 0 are discarded.
  - Its counter never increments; rsBusy/rtBusy = 0 for address 0.
- Write: on the clock edge with wbEn=1 and wbAddr!=0, regs[wbAddr] <= wbData.
- Read ports, combinational, zero latency:
  - rsData = 0 if rsAddr==0.
  - Otherwise rsData = wbData if wbEn && wbAddr==rsAddr.
  - Otherwise rsData = regs[rsAddr].
  - rtData uses identical rules.
- Debug port: dbgData = regs[dbgAddr], with no bypass (0 for address 0).
- Scoreboard, per register r != 0, counter pend[r] updated at the clock edge:
  - inc = issueEn && issueAddr==r.
  - dec = wbEn && wbAddr==r.
  - inc && dec: counter unchanged.
  - inc only: if pend[r] == max, counter holds and sbOverflow <= 1; else pend[r] + 1.
  - dec only: if pend[r] == 0, counter holds at 0 (the write itself still occurs); else pend[r] - 1.
- Busy flags, combinational:
  - rsBusy = (pend[rsAddr] != 0) && !(wbEn && wbAddr==rsAddr && pend[rsAddr]==1).
  - Rationale: the retiring write is bypassed this cycle. rtBusy uses the same rule.
- Flush:
  - At the clock edge, all counters are set to 0, then this cycle's issue is applied. An issue coincident with flush survives with count 1.
  - A wbEn coincident with flush still writes the register.
  - sbOverflow is cleared by flush (flush takes priority over same-cycle overflow detection).
- Simultaneous write and read of the same register: the reader sees new data (bypass); regs updates at the edge.
- Reset mid-operation: all state is discarded, with no partial writes. The first edge after deassert behaves as a fresh start.

Test Plan:
- Reset then read all 32 addresses on rs, rt and dbg -> all 0; all busy=0; sbOverflow=0.
- Write wbEn=1, wbAddr=5, wbData=0xDEADBEEF with rsAddr=5 in the same cycle -> rsData=0xDEADBEEF (bypass) and dbgData=0. Next cycle dbgData=0xDEADBEEF.
- Write wbAddr=0, wbData=0xFFFFFFFF; issue issueAddr=0 -> rsAddr=0 reads 0; rsBusy=0; no counter change.
- Issue to r8 three times, then a 4th -> rsBusy(8)=1 and sbOverflow=1. Three wbEn to r8 -> rsBusy drops in the cycle of the 3rd write (bypass) and is 0 afterwards.
- Same-cycle issue and wb to r9 with pend[9]=1 -> pend stays 1, rtBusy(9)=1. Flush with a concurrent issue to r10 -> pend[9]=0 and pend[10]=1.
- Assert rst asynchronously mid-clock after writes to r3 and issues to r4 -> immediate reads of r3 = 0, rsBusy(4) = 0, sbOverflow = 0.
